// File: rtl/qpp_addr_ctrl.sv
// qpp_addr_ctrl: sequencing controller for the turbo interleaver QPP address path.
// Looks up f1/f2 for the requested block, reduces them modulo K, then walks
// pi(i) = (f1*i + f2*i^2) mod K incrementally using two running sums:
//   pi(i+1) = pi(i) + g(i),  g(i+1) = g(i) + 2*f2   (all mod K)
// with g(0) = f1 + f2. Every modular step is a single conditional subtract
// because both operands are already reduced below K.
module qpp_addr_ctrl #(
    parameter int KW = 13
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [7:0]    k_idx_i,
    input  logic [KW-1:0] k_len_i,
    output logic [7:0]    tbl_idx_o,
    input  logic [8:0]    tbl_f1_i,
    input  logic [9:0]    tbl_f2_i,
    output logic [KW-1:0] addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          addr_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int SW = KW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REDUCE,
        S_SETUP,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    tbl_idx_q, tbl_idx_d;
    logic [SW-1:0] f1_q, f1_d;
    logic [SW-1:0] f2_q, f2_d;
    logic [KW-1:0] g_q, g_d;
    logic [KW-1:0] inc_q, inc_d;
    logic [KW-1:0] pi_q, pi_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [SW-1:0] k_ext;
    logic          f1_ge_k;
    logic          f2_ge_k;
    logic          last;
    logic          handshake;

    // (a + b) mod k for a, b < k: one widened add, one conditional subtract.
    function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                              input logic [KW-1:0] b,
                                              input logic [KW-1:0] k);
        logic [SW-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, k}) begin
            sum = sum - {1'b0, k};
        end
        return sum[KW-1:0];
    endfunction

    assign k_ext     = {1'b0, k_q};
    assign f1_ge_k   = (f1_q >= k_ext);
    assign f2_ge_k   = (f2_q >= k_ext);
    assign last      = (state_q == S_RUN) && (cnt_q == k_q - KW'(1));
    assign handshake = (state_q == S_RUN) && addr_ready_i;

    assign tbl_idx_o    = tbl_idx_q;
    assign addr_o       = pi_q;
    assign addr_valid_o = (state_q == S_RUN);
    assign addr_last_o  = last;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        // NOTE: every target gets a hold/default value up front so no path through the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        tbl_idx_d = tbl_idx_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        g_d       = g_q;
        inc_d     = inc_q;
        pi_d      = pi_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the old block.
                if (start_i && !done_q) begin
                    if (k_len_i < KW'(2)) begin
                        err_d = 1'b1;
                    end else begin
                        k_d       = k_len_i;
                        tbl_idx_d = k_idx_i;
                        state_d   = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                f1_d = SW'(tbl_f1_i);
                f2_d = SW'(tbl_f2_i);
                if (tbl_f1_i == 9'd0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (!f1_ge_k && !f2_ge_k) begin
                    state_d = S_SETUP;
                end else begin
                    if (f1_ge_k) f1_d = f1_q - k_ext;
                    if (f2_ge_k) f2_d = f2_q - k_ext;
                end
            end
            S_SETUP: begin
                g_d     = mod_add(f1_q[KW-1:0], f2_q[KW-1:0], k_q);
                inc_d   = mod_add(f2_q[KW-1:0], f2_q[KW-1:0], k_q);
                pi_d    = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (handshake) begin
                    pi_d  = mod_add(pi_q, g_q, k_q);
                    g_d   = mod_add(g_q, inc_q, k_q);
                    cnt_d = cnt_q + KW'(1);
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst_i) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            tbl_idx_q <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
            g_q       <= '0;
            inc_q     <= '0;
            pi_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tbl_idx_q <= tbl_idx_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            g_q       <= g_d;
            inc_q     <= inc_d;
            pi_q      <= pi_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_qpp_addr_ctrl.sv
// Self-checking bench for qpp_addr_ctrl. The reference is the closed form
// pi(i) = (f1*i + f2*i^2) mod K evaluated directly with wide integers, plus
// latency = 4 + number of reduction cycles.
module tb_qpp_addr_ctrl;

    localparam int KW = 13;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [7:0]    k_idx_i;
    logic [KW-1:0] k_len_i;
    logic [7:0]    tbl_idx_o;
    logic [8:0]    tbl_f1_i;
    logic [9:0]    tbl_f2_i;
    logic [KW-1:0] addr_o;
    logic          addr_valid_o;
    logic          addr_ready_i;
    logic          addr_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    logic [8:0] f1_tab [256];
    logic [9:0] f2_tab [256];
    bit         seen   [8192];

    int n_vec = 0;
    int n_err = 0;

    qpp_addr_ctrl #(.KW(KW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .k_idx_i      (k_idx_i),
        .k_len_i      (k_len_i),
        .tbl_idx_o    (tbl_idx_o),
        .tbl_f1_i     (tbl_f1_i),
        .tbl_f2_i     (tbl_f2_i),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .addr_last_o  (addr_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational parameter table.
    assign tbl_f1_i = f1_tab[tbl_idx_o];
    assign tbl_f2_i = f2_tab[tbl_idx_o];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_pi(input longint f1, input longint f2,
                                      input longint k, input longint i);
        return (f1 * i + f2 * i * i) % k;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Pulses start at an edge; returns at the falling edge of cycle 1.
    task automatic do_start(input int kidx, input int klen);
        start_i = 1'b1;
        k_idx_i = 8'(kidx);
        k_len_i = KW'(klen);
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic run_block(input int kidx, input int klen, input int f1, input int f2,
                             input bit rand_ready, input bit perm, input int abort_at,
                             input bit poke_start);
        int  cyc;
        int  i;
        int  guard;
        int  exp_lat;
        int  n_seen;
        bit  ready;
        f1_tab[kidx] = 9'(f1);
        f2_tab[kidx] = 10'(f2);
        for (int a = 0; a < 8192; a++) seen[a] = 1'b0;
        addr_ready_i = 1'b0;
        do_start(kidx, klen);
        check("busy_after_start", busy_o, 1);
        check("tbl_idx", tbl_idx_o, kidx);

        exp_lat = 4 + max2(f1 / klen, f2 / klen);
        cyc = 1;
        while (!addr_valid_o && cyc < 1000) begin
            @(negedge clk_i);
            cyc++;
        end
        check("latency", cyc, exp_lat);

        i = 0;
        guard = 0;
        while (i < klen && guard < 20 * klen + 100) begin
            check("valid", addr_valid_o, 1);
            check("addr", addr_o, ref_pi(f1, f2, klen, i));
            check("last", addr_last_o, (i == klen - 1));
            check("busy", busy_o, 1);
            check("err_quiet", err_o, 0);
            check("tbl_idx_hold", tbl_idx_o, kidx);
            if (poke_start && i == 5) begin
                start_i = 1'b1;
                k_idx_i = 8'(kidx ^ 8'h55);
                k_len_i = KW'(klen + 7);
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            addr_ready_i = ready;
            @(posedge clk_i);
            if (ready) begin
                if (perm) check("no_duplicate", seen[addr_o], 0);
                seen[addr_o] = 1'b1;
                i++;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            guard++;
            if (abort_at >= 0 && i == abort_at) begin
                addr_ready_i = 1'b0;
                rst_i = 1'b1;
                @(posedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b0;
                check("abort_valid", addr_valid_o, 0);
                check("abort_busy", busy_o, 0);
                check("abort_done", done_o, 0);
                check("abort_err", err_o, 0);
                return;
            end
        end
        check("handshakes", i, klen);
        addr_ready_i = 1'b0;

        check("done_pulse", done_o, 1);
        check("busy_fall", busy_o, 0);
        check("valid_fall", addr_valid_o, 0);
        // A start in the done cycle must be ignored.
        start_i = 1'b1;
        k_idx_i = 8'(kidx);
        k_len_i = KW'(klen);
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        check("done_clear", done_o, 0);
        check("start_in_done_ignored", busy_o, 0);

        if (perm) begin
            n_seen = 0;
            for (int a = 0; a < klen; a++) n_seen += int'(seen[a]);
            check("permutation", n_seen, klen);
        end
    endtask

    task automatic do_reset(input bit check_vals);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        if (check_vals) begin
            check("rst_tbl_idx", tbl_idx_o, 0);
            check("rst_addr", addr_o, 0);
            check("rst_valid", addr_valid_o, 0);
            check("rst_last", addr_last_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_err", err_o, 0);
        end
    endtask

    initial begin
        int k, f1, f2, idx;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        k_idx_i      = '0;
        k_len_i      = '0;
        addr_ready_i = 1'b0;
        for (int a = 0; a < 256; a++) begin
            f1_tab[a] = 9'd1;
            f2_tab[a] = 10'd0;
        end
        @(negedge clk_i);
        do_reset(1'b1);

        // Basic sequence, then the same permutation via two reduction cycles.
        run_block(3, 40, 3, 10, 1'b0, 1'b1, -1, 1'b0);
        run_block(4, 40, 3, 90, 1'b0, 1'b1, -1, 1'b0);
        // Backpressure with an ignored mid-run start.
        run_block(3, 40, 3, 10, 1'b1, 1'b1, -1, 1'b1);

        // Reject: block length below 2.
        do_start(7, 1);
        check("rej_len_err", err_o, 1);
        check("rej_len_busy", busy_o, 0);
        @(negedge clk_i);
        check("rej_len_err_clear", err_o, 0);
        check("rej_len_busy2", busy_o, 0);

        // Reject: unsupported table entry.
        f1_tab[9] = 9'd0;
        f2_tab[9] = 10'd5;
        do_start(9, 40);
        check("rej_f1_busy", busy_o, 1);
        check("rej_f1_err_early", err_o, 0);
        @(negedge clk_i);
        check("rej_f1_err", err_o, 1);
        check("rej_f1_busy_fall", busy_o, 0);
        check("rej_f1_valid", addr_valid_o, 0);
        @(negedge clk_i);
        check("rej_f1_err_clear", err_o, 0);
        check("rej_f1_valid2", addr_valid_o, 0);

        // Reset after the 10th handshake, then a fresh block without extra reset.
        run_block(3, 40, 3, 10, 1'b1, 1'b1, 10, 1'b0);
        run_block(3, 40, 3, 10, 1'b0, 1'b1, -1, 1'b0);

        // Large block length.
        run_block(11, 6144, 263, 480, 1'b0, 1'b1, -1, 1'b0);

        // Random parameters; not necessarily permutations.
        for (int t = 0; t < 6; t++) begin
            k   = int'($urandom_range(2, 300));
            f1  = int'($urandom_range(1, 511));
            f2  = int'($urandom_range(0, 1023));
            idx = int'($urandom_range(16, 255));
            run_block(idx, k, f1, f2, 1'b1, 1'b0, -1, (t % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qpp_addr_ctrl.md
# qpp_addr_ctrl

Sequencing controller for the turbo interleaver's QPP address path. On a start request it drives the block-size index to the f1/f2 parameter table, captures the returned coefficients and reduces them modulo K. It then emits the interleaved address sequence pi(i) = (f1·i + f2·i²) mod K, i = 0..K-1, one address per accepted handshake. It sits between the interleaver top-level control and the memory read-address port, with the f1/f2 table as its only arithmetic resource.

## Interface
- KW, 13, width of block length K and of generated addresses
- clk  input  1  clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- k_idx  input  8  table index for this block; sampled with start
- k_len  input  KW  block length K; sampled with start
- tbl_idx  output  8  index driven to f1/f2 table, held from start until next start
- tbl_f1  input  9  f1 returned by table (combinational from tbl_idx)
- tbl_f2  input  10  f2 returned by table
- addr  output  KW  current interleaved address pi(i)
- addr_valid  output  1  addr is valid
- addr_ready  input  1  consumer accepts addr when valid && ready
- addr_last  output  1  high with the address for i = K-1
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last address is accepted
- err  output  1  one-cycle pulse when a request is rejected

## Operation
- States: IDLE, LOOKUP, REDUCE, SETUP, RUN.
- **IDLE.** On start, latch k_len into K_r and k_idx into tbl_idx, then go to LOOKUP. If k_len < 2, stay in IDLE and pulse err instead. start in any other state is ignored.
- **LOOKUP** (1 cycle):
  - Capture tbl_f1 and tbl_f2 into f1_r and f2_r (zero-extended to KW+1 bits).
  - If tbl_f1 == 0 (unsupported table entry), pulse err and return to IDLE without emitting addresses.
  - Otherwise go to REDUCE.
- **REDUCE.** Each cycle, independently: if f1_r ≥ K_r then f1_r -= K_r; if f2_r ≥ K_r then f2_r -= K_r. When both are already < K_r, go to SETUP with no further subtraction.
- **SETUP** (1 cycle):
  - g_r = (f1_r + f2_r) mod K_r.
  - inc_r = (2·f2_r) mod K_r.
  - pi_r = 0, cnt_r = 0.
  - Go to RUN.
  - Each mod is a single conditional subtract, since both operands are < K_r.
- **RUN.** addr = pi_r, addr_valid = 1, addr_last = (cnt_r == K_r-1). On handshake:
  - pi_r ← (pi_r + g_r) mod K_r
  - g_r ← (g_r + inc_r) mod K_r
  - cnt_r ← cnt_r + 1
  - Each mod is a single conditional subtract; sums use KW+1 bits.
  - When the handshake occurs with addr_last = 1, go to IDLE and pulse done in the following cycle.
  - Without a handshake, addr, addr_last and all registers hold.
- All addresses lie in [0, K-1]. The sequence is a permutation of 0..K-1 for valid table entries.

## Timing
- Reset values: state IDLE; tbl_idx 0; addr 0; addr_valid 0; addr_last 0; busy 0; done 0; err 0; internal registers 0.
- rst high in any state aborts the block in the next cycle: addr_valid drops and no done or err is issued.
- Start-to-first-address latency, with start sampled at edge 0:
  - LOOKUP in cycle 1, REDUCE in cycle 2, SETUP in cycle 3.
  - addr_valid high in cycle 4 when no reduction is needed.
  - Each REDUCE subtraction adds one cycle.
- Throughput in RUN: one address per cycle while addr_ready is held high.
- addr_valid never deasserts in RUN until the last handshake; addr_ready is never required before addr_valid.
- busy rises the cycle after start is accepted and falls the cycle after the last handshake (the same cycle done pulses).
- err pulses the cycle after the rejected start (k_len < 2), or the cycle after LOOKUP (f1 == 0).
- A start arriving in the same cycle as done is ignored; the block accepts start from the next cycle.

## Test plan
- **Basic sequence.** k_len=40, table returns f1=3, f2=10, addr_ready=1.
  - Required addresses in order: 0, 13, 6, 19, …
  - addr_valid first high 4 cycles after start.
  - Exactly 40 handshakes; addr_last only on the 40th; done one cycle later.
  - The 40 addresses are a permutation of 0..39.
- **Reduction.** k_len=40, f1=3, f2=90.
  - Two REDUCE subtraction cycles, so addr_valid first high at cycle 6.
  - Sequence identical to f2=10.
- **Backpressure.** Repeat the basic case with addr_ready toggling pseudo-randomly.
  - addr and addr_last hold while ready is low.
  - Same sequence, no duplicates, no drops.
- **Rejects.**
  - start with k_len=1 → err pulse at cycle 1, busy stays 0.
  - Table returning f1=0 → err pulse after LOOKUP, no addr_valid.
- **Ignored start.** A second start mid-RUN with different k_idx/k_len → sequence unaffected and tbl_idx unchanged.
- **Reset mid-run.** rst asserted after the 10th handshake.
  - Next cycle: addr_valid=0, busy=0, no done.
  - A new start then produces a fresh sequence from 0.
